maxpool_flatten_buffer: RTL

- Streaming 2x2/stride-2 max-pool plus flatten stage directly upstream of the fully-connected layer.
- Accepts the conv-stage feature map one pixel per beat in raster order and reduces it to a 15x15 map.
- Holds the result as a 225-entry flattened array and drives the FC start/hand-off protocol.
- Frees the FC layer from any knowledge of frame geometry.

---
 rtl/maxpool_flatten_buffer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/maxpool_flatten_buffer.sv
// Purpose : streaming 2x2/stride-2 signed max-pool + flatten feeding the FC layer start/done hand-off.
// Latency : pooled value lands in o_flattened_data on the accepting edge; o_start rises the cycle after the last pixel.
// Backpressure: o_ready drops from the final pixel until the FC layer finishes and releases i_fc_done.
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-low reset
//   i_valid/i_data    - raster-order pixel stream, accepted when i_valid && o_ready
//   o_ready           - high only in FILL
//   o_flattened_data  - pooled map, index = (r/2)*(IN_W/2) + c/2, frozen while o_start/RELEASE
//   o_start/i_fc_done - level hand-off to the FC layer
//   o_frame_cnt       - frames handed off, wraps at 255
// Optional: define POOL_RELU_EN to clamp stored pooled values at zero (line buffer keeps raw values).
module maxpool_flatten_buffer #(
    parameter  int DATA_W = 22,
    parameter  int IN_W   = 30,
    parameter  int IN_H   = 30,
    localparam int OUT_N  = (IN_W / 2) * (IN_H / 2)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_data,
    output logic                     o_ready,
    output logic signed [DATA_W-1:0] o_flattened_data [0:OUT_N-1],
    output logic                     o_start,
    input  logic                     i_fc_done,
    output logic [7:0]               o_frame_cnt
);

    localparam int HALF_W   = IN_W / 2;
    localparam int COL_BITS = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int ROW_BITS = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int IDX_BITS = (OUT_N > 1) ? $clog2(OUT_N) : 1;
    localparam int LB_BITS  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        HANDOFF = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                     state;
    logic [COL_BITS-1:0]        col;
    logic [ROW_BITS-1:0]        row;
    logic signed [DATA_W-1:0]   pair_q;
    logic signed [DATA_W-1:0]   lb [0:HALF_W-1];

    logic                       accept;
    logic                       last_pix;
    logic [LB_BITS-1:0]         lb_idx;
    logic [IDX_BITS-1:0]        out_idx;
    logic signed [DATA_W-1:0]   pair_max;
    logic signed [DATA_W-1:0]   pool_val;
    logic signed [DATA_W-1:0]   store_val;

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    assign accept   = i_valid && o_ready;
    assign last_pix = (row == ROW_BITS'(IN_H - 1)) && (col == COL_BITS'(IN_W - 1));
    assign lb_idx   = LB_BITS'(col >> 1);
    assign out_idx  = IDX_BITS'(32'(row >> 1) * HALF_W + 32'(col >> 1));

    // Horizontal pair max, then fold in the even row held in the line buffer.
    assign pair_max = smax(pair_q, i_data);
    assign pool_val = smax(lb[lb_idx], pair_max);

`ifdef POOL_RELU_EN
    assign store_val = pool_val[DATA_W-1] ? '0 : pool_val;
`else
    assign store_val = pool_val;
`endif

    // Control, counters and pooling state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FILL;
            row         <= '0;
            col         <= '0;
            pair_q      <= '0;
            o_ready     <= 1'b1;
            o_start     <= 1'b0;
            o_frame_cnt <= '0;
            for (int i = 0; i < HALF_W; i++) begin
                lb[i] <= '0;
            end
        end else begin
            if (accept) begin
                if (!col[0]) begin
                    pair_q <= i_data;
                end else if (!row[0]) begin
                    lb[lb_idx] <= pair_max;
                end

                if (col == COL_BITS'(IN_W - 1)) begin
                    col <= '0;
                    row <= (row == ROW_BITS'(IN_H - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            case (state)
                FILL: begin
                    // i_fc_done is deliberately not looked at here.
                    if (accept && last_pix) begin
                        state   <= HANDOFF;
                        o_ready <= 1'b0;
                        o_start <= 1'b1;
                    end
                end
                HANDOFF: begin
                    if (i_fc_done) begin
                        state       <= RELEASE;
                        o_start     <= 1'b0;
                        o_frame_cnt <= o_frame_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    // Wait for done to drop so start is seen low before it can rise again.
                    if (!i_fc_done) begin
                        state   <= FILL;
                        o_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= FILL;
                    o_ready <= 1'b1;
                    o_start <= 1'b0;
                end
            endcase
        end
    end

    // Flattened result array; written only on odd-row/odd-col accepted beats, so it is
    // naturally frozen outside FILL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < OUT_N; i++) begin
                o_flattened_data[i] <= '0;
            end
        end else if (accept && col[0] && row[0]) begin
            o_flattened_data[out_idx] <= store_val;
        end
    end

endmodule
